// File: rtl/contador_prog.sv
// contador_prog: programmable up/down counter with range 0..max_val.
// Priority each cycle: load, then count enable, then hold.
// Boundary mode is selected at build time by the macro CONTADOR_PROG_SAT_EN:
//   undefined -> the count wraps at 0 and max_val
//   defined   -> the count saturates at 0 and max_val
// tc is a registered flag that is set on every enabled cycle that hits a boundary.
module contador_prog #(
   parameter int NBITS = 8,
   parameter int INIT  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [NBITS-1:0] load_val,
   input  logic [NBITS-1:0] max_val,
   output logic [NBITS-1:0] out,
   output logic             tc
);

   localparam logic [NBITS-1:0] INIT_V = INIT[NBITS-1:0];
   localparam logic [NBITS-1:0] ONE    = NBITS'(1);

   logic [NBITS-1:0] out_q, out_d;
   logic             tc_q, tc_d;

   // Next count and terminal-count flag from load / enable / direction.
   always_comb begin
      out_d = out_q;
      tc_d  = 1'b0;
      if (load) begin
         // Clamp the loaded value into the legal range.
         out_d = (load_val > max_val) ? max_val : load_val;
      end else if (en) begin
         if (out_q > max_val) begin
            // max_val was lowered below the current count.
`ifdef CONTADOR_PROG_SAT_EN
            out_d = max_val;
`else
            out_d = '0;
`endif
            tc_d  = 1'b1;
         end else if (up) begin
            if (out_q == max_val) begin
`ifdef CONTADOR_PROG_SAT_EN
               out_d = max_val;
`else
               out_d = '0;
`endif
               tc_d  = 1'b1;
            end else begin
               out_d = out_q + ONE;
            end
         end else begin
            if (out_q == '0) begin
`ifdef CONTADOR_PROG_SAT_EN
               out_d = '0;
`else
               out_d = max_val;
`endif
               tc_d  = 1'b1;
            end else begin
               out_d = out_q - ONE;
            end
         end
      end
   end

   // State register; reset forces INIT immediately, independent of clk.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q <= INIT_V;
         tc_q  <= 1'b0;
      end else begin
         out_q <= out_d;
         tc_q  <= tc_d;
      end
   end

   assign out = out_q;
   assign tc  = tc_q;

endmodule

// File: tb/tb_contador_prog.sv
// Self-checking bench for contador_prog (either boundary mode, chosen by
// CONTADOR_PROG_SAT_EN at compile time).
module tb_contador_prog;

`ifdef CONTADOR_PROG_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   // 4-bit instance, INIT=3
   logic       en4 = 0, up4 = 0, ld4 = 0;
   logic [3:0] lv4 = 0, mv4 = 0, out4;
   logic       tc4;
   // 8-bit instance, INIT=0
   logic       en8 = 0, up8 = 0, ld8 = 0;
   logic [7:0] lv8 = 0, mv8 = 0, out8;
   logic       tc8;
   // 1-bit instance, INIT=0
   logic       en1 = 0, up1 = 0, ld1 = 0;
   logic [0:0] lv1 = 0, mv1 = 0, out1;
   logic       tc1;

   contador_prog #(.NBITS(4), .INIT(3)) dut4 (
      .clk(clk), .reset(reset), .en(en4), .up(up4), .load(ld4),
      .load_val(lv4), .max_val(mv4), .out(out4), .tc(tc4));
   contador_prog #(.NBITS(8), .INIT(0)) dut8 (
      .clk(clk), .reset(reset), .en(en8), .up(up8), .load(ld8),
      .load_val(lv8), .max_val(mv8), .out(out8), .tc(tc8));
   contador_prog #(.NBITS(1), .INIT(0)) dut1 (
      .clk(clk), .reset(reset), .en(en1), .up(up1), .load(ld1),
      .load_val(lv1), .max_val(mv1), .out(out1), .tc(tc1));

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [4:0] exp_q[$];

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Expected value depending on boundary mode.
   function automatic int pick(input int wrap_v, input int sat_v);
      return SAT ? sat_v : wrap_v;
   endfunction

   // Reference model from the counting rules, in plain integer arithmetic
   // over the ring 0..mv (wrap) or the clamped interval 0..mv (saturate).
   function automatic void model(input int cur, input bit ld, input bit en,
                                 input bit up, input int lv, input int mv,
                                 output int nxt, output bit t);
      nxt = cur;
      t   = 1'b0;
      if (ld) begin
         nxt = (lv < mv) ? lv : mv;
      end else if (en) begin
         if (cur > mv) begin
            nxt = SAT ? mv : 0;
            t   = 1'b1;
         end else if (SAT) begin
            t   = up ? (cur == mv) : (cur == 0);
            nxt = up ? ((cur + 1 > mv) ? mv : cur + 1) : ((cur == 0) ? 0 : cur - 1);
         end else begin
            nxt = up ? (cur + 1) % (mv + 1) : (cur + mv) % (mv + 1);
            t   = up ? (nxt == 0) : (cur == 0);
         end
      end
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive4(input bit ld, input bit en, input bit up,
                         input int lv, input int mv);
      @(negedge clk);
      ld4 = ld; en4 = en; up4 = up; lv4 = 4'(lv); mv4 = 4'(mv);
      @(posedge clk);
      #1;
   endtask

   task automatic drive8(input bit ld, input bit en, input bit up,
                         input int lv, input int mv);
      @(negedge clk);
      ld8 = ld; en8 = en; up8 = up; lv8 = 8'(lv); mv8 = 8'(mv);
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input bit ld, input bit en, input bit up,
                         input int lv, input int mv);
      @(negedge clk);
      ld1 = ld; en1 = en; up1 = up; lv1 = 1'(lv); mv1 = 1'(mv);
      @(posedge clk);
      #1;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit ld; bit en; bit up; int lv; int mv; int eo; bit et;
   } vec_t;
   vec_t tbl[$];

   task automatic add(input bit ld, input bit en, input bit up, input int lv,
                      input int mv, input int eo, input bit et);
      vec_t v;
      v.ld = ld; v.en = en; v.up = up; v.lv = lv; v.mv = mv; v.eo = eo; v.et = et;
      tbl.push_back(v);
   endtask

   initial begin
      int cur;
      int nxt;
      bit t;
      logic [4:0] e;

      // Table: load clamp/priority, boundaries, lowering max_val, max_val=0.
      add(1, 1, 1, 12, 7, 7, 0);
      add(0, 1, 1, 0, 7, pick(0, 7), 1);
      add(0, 1, 1, 0, 7, pick(1, 7), pick(0, 1));
      add(0, 0, 1, 0, 7, pick(1, 7), 0);
      add(1, 0, 0, 0, 5, 0, 0);
      for (int i = 1; i <= 5; i++) add(0, 1, 1, 0, 5, i, 0);
      add(0, 1, 1, 0, 5, pick(0, 5), 1);
      add(1, 0, 1, 6, 9, 6, 0);
      add(0, 1, 1, 0, 3, pick(0, 3), 1);
      add(0, 1, 0, 0, 3, pick(3, 2), pick(1, 0));
      add(0, 1, 0, 0, 3, pick(2, 1), 0);
      add(1, 1, 0, 0, 0, 0, 0);
      add(0, 1, 1, 0, 0, 0, 1);
      add(0, 1, 0, 0, 0, 0, 1);
      add(1, 0, 0, 15, 15, 15, 0);
      add(0, 1, 1, 0, 15, pick(0, 15), 1);

      // Reset state
      #12;
      check("reset_out4", out4, 3);
      check("reset_tc4", tc4, 0);
      check("reset_out8", out8, 0);
      check("reset_out1", out1, 0);
      @(negedge clk);
      reset = 1'b1;

      foreach (tbl[i]) begin
         drive4(tbl[i].ld, tbl[i].en, tbl[i].up, tbl[i].lv, tbl[i].mv);
         check($sformatf("tbl%0d_out", i), out4, tbl[i].eo);
         check($sformatf("tbl%0d_tc", i), tc4, tbl[i].et);
      end

      // Reset pulse between edges, with load/en active during reset.
      @(negedge clk);
      ld4 = 1; en4 = 1; up4 = 1; lv4 = 9; mv4 = 15;
      reset = 1'b0;
      #1;
      check("async_rst_out", out4, 3);
      check("async_rst_tc", tc4, 0);
      @(posedge clk);
      #1;
      check("rst_ignores_load", out4, 3);
      @(negedge clk);
      reset = 1'b1;
      ld4 = 0;
      @(posedge clk);
      #1;
      check("first_edge_after_rst", out4, 4);

      // Down-wrap on the 8-bit instance, max_val=9, from 0.
      drive8(1, 0, 0, 0, 9);
      check("dn_load", out8, 0);
      drive8(0, 1, 0, 0, 9);
      check("dn_b_out", out8, pick(9, 0));
      check("dn_b_tc", tc8, 1);
      for (int k = 1; k <= 3; k++) begin
         drive8(0, 1, 0, 0, 9);
         check($sformatf("dn%0d_out", k), out8, pick(9 - k, 0));
         check($sformatf("dn%0d_tc", k), tc8, pick(0, 1));
      end
      // Direction change with no idle cycle.
      drive8(0, 1, 1, 0, 9);
      check("dir_change", out8, pick(7, 1));

      // 1-bit instance, max_val=1, counting up from 0.
      drive1(1, 0, 1, 0, 1);
      for (int k = 0; k < 4; k++) begin
         drive1(0, 1, 1, 0, 1);
         check($sformatf("nb1_%0d_out", k), out1, pick((k % 2 == 0) ? 1 : 0, 1));
         check($sformatf("nb1_%0d_tc", k), tc1, pick(k % 2, (k == 0) ? 0 : 1));
      end

      // Randomized run on the 4-bit instance against the model.
      drive4(1, 0, 0, 0, 15);
      cur = 0;
      for (int n = 0; n < 400; n++) begin
         bit ld, en, up;
         int lv, mv;
         ld = ($urandom_range(0, 7) == 0);
         en = ($urandom_range(0, 3) != 0);
         up = $urandom_range(0, 1);
         lv = $urandom_range(0, 15);
         mv = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : mv4;
         if (n % 50 == 0) mv = $urandom_range(0, 15);
         model(cur, ld, en, up, lv, mv, nxt, t);
         cur = nxt;
         exp_q.push_back({t, 4'(nxt)});
         drive4(ld, en, up, lv, mv);
         e = exp_q.pop_front();
         check($sformatf("rnd%0d_out", n), out4, e[3:0]);
         check($sformatf("rnd%0d_tc", n), tc4, e[4]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
